// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle RV32I control unit.
// Imported by the control FSM and its ALU decoder.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLL = 4'd5,
    ALU_SRL = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SLA = 4'd8
  } alu_control_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_TRAP     = 4'd12
  } ctrl_state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  function automatic logic is_req_state(
    ctrl_state_t s
  );
    return (s == S_FETCH) ||
           (s == S_MEMREAD) ||
           (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode from funct3/funct7b5.
// SUB only for R-type; SLA is never produced.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic         is_r,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  output alu_control_t alu_control
);

  // Map funct3 (and funct7b5) onto an ALU op
  always_comb begin
    alu_control = ALU_ADD;
    unique case (funct3)
      3'b000: alu_control = (is_r && funct7b5)
                            ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7b5
                            ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      3'b111: alu_control = ALU_AND;
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I datapath.
// One instruction in flight; sticky TRAP on bad encodings.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [6:0]   opcode,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  input  logic         zero,
  input  logic         mem_ready,
  output logic         mem_req,
  output logic         mem_write,
  output logic         adr_src,
  output logic         ir_write,
  output logic         pc_write,
  output logic         reg_write,
  output logic [1:0]   result_src,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [2:0]   imm_src,
  output alu_control_t alu_control,
  output logic         illegal
);

  localparam int CW = (MEM_WAIT_MAX > 0)
                      ? $clog2(MEM_WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] WAIT_LAST =
    CW'((MEM_WAIT_MAX > 0) ? MEM_WAIT_MAX - 1 : 0);

  ctrl_state_t   state_q, state_d;
  logic [CW-1:0] wait_q, wait_d;

  logic         is_r;
  alu_control_t dec_alu;
  logic         stall;
  logic         timeout;
  logic         f3_ls_ok;
  logic         f3_alu_ok;
  logic         f3_br_ok;

  assign is_r  = (state_q == S_EXECR);
  assign stall = is_req_state(state_q) && !mem_ready;

  // The last permitted stall cycle forces TRAP
  assign timeout = (MEM_WAIT_MAX > 0) && stall &&
                   (wait_q == WAIT_LAST);

  assign f3_ls_ok  = (funct3 == 3'b010);
  assign f3_alu_ok = (funct3 != 3'b010) &&
                     (funct3 != 3'b011);
  assign f3_br_ok  = (funct3 == 3'b000) ||
                     (funct3 == 3'b001);

  multicycle_control_alu_decoder u_alu_dec (
    .is_r        (is_r),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .alu_control (dec_alu)
  );

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Stall counter restarts on completion or state change
  always_comb begin
    wait_d = '0;
    if (stall && (state_d == state_q)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Next state and datapath controls
  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    imm_src     = IMM_I;
    alu_control = ALU_ADD;
    illegal     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_src   = (opcode == OP_JAL)
                    ? IMM_J : IMM_B;
        unique case (1'b1)
          ((opcode == OP_LOAD) ||
           (opcode == OP_STORE)) && f3_ls_ok:
            state_d = S_MEMADR;
          (opcode == OP_R) && f3_alu_ok:
            state_d = S_EXECR;
          (opcode == OP_I) && f3_alu_ok:
            state_d = S_EXECI;
          (opcode == OP_BRANCH) && f3_br_ok:
            state_d = S_BRANCH;
          (opcode == OP_JAL):
            state_d = S_JAL;
          (opcode == OP_LUI):
            state_d = S_LUI;
          default:
            state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        if (opcode == OP_LOAD) begin
          imm_src = IMM_I;
          state_d = S_MEMREAD;
        end else begin
          imm_src = IMM_S;
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_RDATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = dec_alu;
        state_d     = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        imm_src     = IMM_I;
        alu_control = dec_alu;
        state_d     = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_RS2;
        alu_control = ALU_SUB;
        result_src  = RES_ALUOUT;
        pc_write    = (funct3 == 3'b000)
                      ? zero : ~zero;
        state_d     = S_FETCH;
      end
      S_JAL: begin
        result_src = RES_ALUOUT;
        pc_write   = 1'b1;
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        state_d    = S_ALUWB;
      end
      S_LUI: begin
        alu_src_a = SRCA_ZERO;
        alu_src_b = SRCB_IMM;
        imm_src   = IMM_U;
        state_d   = S_ALUWB;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_TRAP;
      end
    endcase

    if (timeout) state_d = S_TRAP;

    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      result_src  = 2'b00;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      imm_src     = 3'b000;
      alu_control = ALU_ADD;
      illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control.
// Expected cycles come from an instruction-level model.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  localparam int MAXW = 4;

  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  localparam logic [6:0] L_LOAD   = 7'b0000011;
  localparam logic [6:0] L_STORE  = 7'b0100011;
  localparam logic [6:0] L_R      = 7'b0110011;
  localparam logic [6:0] L_I      = 7'b0010011;
  localparam logic [6:0] L_BRANCH = 7'b1100011;
  localparam logic [6:0] L_JAL    = 7'b1101111;
  localparam logic [6:0] L_LUI    = 7'b0110111;

  localparam logic [1:0] R_AOUT = 2'b00;
  localparam logic [1:0] R_RD   = 2'b01;
  localparam logic [1:0] R_ALU  = 2'b10;
  localparam logic [1:0] A_PC   = 2'b00;
  localparam logic [1:0] A_OLD  = 2'b01;
  localparam logic [1:0] A_RS1  = 2'b10;
  localparam logic [1:0] A_ZERO = 2'b11;
  localparam logic [1:0] B_RS2  = 2'b00;
  localparam logic [1:0] B_IMM  = 2'b01;
  localparam logic [1:0] B_FOUR = 2'b10;
  localparam logic [2:0] I_I = 3'b000;
  localparam logic [2:0] I_S = 3'b001;
  localparam logic [2:0] I_B = 3'b010;
  localparam logic [2:0] I_J = 3'b011;
  localparam logic [2:0] I_U = 3'b100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [6:0]   opcode = '0;
  logic [2:0]   funct3 = '0;
  logic         funct7b5 = 1'b0;
  logic         zero = 1'b0;
  logic         mem_ready = 1'b1;
  logic         mem_req;
  logic         mem_write;
  logic         adr_src;
  logic         ir_write;
  logic         pc_write;
  logic         reg_write;
  logic [1:0]   result_src;
  logic [1:0]   alu_src_a;
  logic [1:0]   alu_src_b;
  logic [2:0]   imm_src;
  alu_control_t alu_control;
  logic         illegal;

  multicycle_control #(
    .MEM_WAIT_MAX (MAXW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_write   (mem_write),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  logic [19:0] outv;
  assign outv = {mem_req, mem_write, adr_src,
                 ir_write, pc_write, reg_write,
                 result_src, alu_src_a, alu_src_b,
                 imm_src, alu_control, illegal};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(string tag,
                     logic [19:0] got,
                     logic [19:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h exp %h",
                  tag, got, exp);
  endtask

  function automatic logic [19:0] mk(
    logic req, logic wr, logic adr,
    logic irw, logic pcw, logic rgw,
    logic [1:0] rs, logic [1:0] sa,
    logic [1:0] sb, logic [2:0] imm,
    alu_control_t alu, logic ill);
    return {req, wr, adr, irw, pcw, rgw,
            rs, sa, sb, imm, alu, ill};
  endfunction

  function automatic alu_control_t alu_ref(
    logic r, logic [2:0] f3, logic f7);
    case (f3)
      3'b000:  return (r && f7) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b100:  return ALU_XOR;
      3'b101:  return f7 ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      3'b111:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

  // One cycle: drive mem_ready, check at negedge
  task automatic step(string tag, logic rdy,
                      logic [19:0] exp);
    mem_ready = rdy;
    @(negedge clk);
    chk(tag, outv, exp);
    @(posedge clk);
    #1;
  endtask

  // Stalled request cycles, then completion
  task automatic mem_phase(string tag, int waits,
                           logic [19:0] ew,
                           logic [19:0] ed,
                           output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < waits; i++) begin
      step(tag, 1'b0, ew);
      if (i + 1 == MAXW) begin
        trapped = 1'b1;
        break;
      end
    end
    if (!trapped) step(tag, 1'b1, ed);
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      step("reset", 1'b1,
           mk(N, N, N, N, N, N, R_AOUT, A_PC,
              B_RS2, I_I, ALU_ADD, N));
    end
    rst_n = 1'b1;
  endtask

  task automatic trap_hold(int n);
    for (int i = 0; i < n; i++) begin
      opcode   = 7'($urandom);
      funct3   = 3'($urandom);
      funct7b5 = 1'($urandom);
      zero     = 1'($urandom);
      step("trap", 1'($urandom),
           mk(N, N, N, N, N, N, R_AOUT, A_PC,
              B_RS2, I_I, ALU_ADD, Y));
    end
  endtask

  task automatic run_instr(logic [6:0] op,
                           logic [2:0] f3,
                           logic f7, logic z,
                           int fw, int mw);
    bit tr;
    logic [19:0] v;
    logic [19:0] wb;
    opcode   = op;
    funct3   = f3;
    funct7b5 = f7;
    zero     = z;
    wb = mk(N, N, N, N, N, Y, R_AOUT, A_PC,
            B_RS2, I_I, ALU_ADD, N);
    mem_phase("fetch", fw,
              mk(Y, N, N, N, N, N, R_ALU, A_PC,
                 B_FOUR, I_I, ALU_ADD, N),
              mk(Y, N, N, Y, Y, N, R_ALU, A_PC,
                 B_FOUR, I_I, ALU_ADD, N), tr);
    if (!tr) begin
      step("decode", 1'($urandom),
           mk(N, N, N, N, N, N, R_AOUT, A_OLD,
              B_IMM, (op == L_JAL) ? I_J : I_B,
              ALU_ADD, N));
      if ((op == L_LOAD || op == L_STORE) &&
          f3 == 3'b010) begin
        step("memadr", 1'($urandom),
             mk(N, N, N, N, N, N, R_AOUT, A_RS1,
                B_IMM,
                (op == L_LOAD) ? I_I : I_S,
                ALU_ADD, N));
        if (op == L_LOAD) begin
          v = mk(Y, N, Y, N, N, N, R_AOUT, A_PC,
                 B_RS2, I_I, ALU_ADD, N);
          mem_phase("memread", mw, v, v, tr);
          if (!tr) begin
            step("memwb", 1'($urandom),
                 mk(N, N, N, N, N, Y, R_RD, A_PC,
                    B_RS2, I_I, ALU_ADD, N));
          end
        end else begin
          v = mk(Y, Y, Y, N, N, N, R_AOUT, A_PC,
                 B_RS2, I_I, ALU_ADD, N);
          mem_phase("memwrite", mw, v, v, tr);
        end
      end else if ((op == L_R || op == L_I) &&
                   f3 != 3'b010 &&
                   f3 != 3'b011) begin
        step((op == L_R) ? "execr" : "execi",
             1'($urandom),
             mk(N, N, N, N, N, N, R_AOUT, A_RS1,
                (op == L_R) ? B_RS2 : B_IMM, I_I,
                alu_ref(op == L_R, f3, f7), N));
        step("aluwb", 1'($urandom), wb);
      end else if (op == L_BRANCH &&
                   (f3 == 3'b000 ||
                    f3 == 3'b001)) begin
        step("branch", 1'($urandom),
             mk(N, N, N, N,
                (f3 == 3'b000) ? z : ~z, N,
                R_AOUT, A_RS1, B_RS2, I_I,
                ALU_SUB, N));
      end else if (op == L_JAL) begin
        step("jal", 1'($urandom),
             mk(N, N, N, N, Y, N, R_AOUT, A_OLD,
                B_FOUR, I_I, ALU_ADD, N));
        step("aluwb", 1'($urandom), wb);
      end else if (op == L_LUI) begin
        step("lui", 1'($urandom),
             mk(N, N, N, N, N, N, R_AOUT, A_ZERO,
                B_IMM, I_U, ALU_ADD, N));
        step("aluwb", 1'($urandom), wb);
      end else begin
        tr = 1'b1;
      end
    end
    if (tr) begin
      trap_hold(10 + int'($urandom_range(0, 3)));
      do_reset(1 + int'($urandom_range(0, 1)));
    end
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 19) == 0) return MAXW;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    do_reset(2);
    run_instr(L_R, 3'b000, N, N, 0, 0);
    run_instr(L_R, 3'b000, Y, N, 0, 0);
    run_instr(L_LOAD, 3'b010, N, N, 0, 3);
    run_instr(L_BRANCH, 3'b000, N, Y, 0, 0);
    run_instr(L_BRANCH, 3'b001, N, Y, 0, 0);
    run_instr(L_BRANCH, 3'b001, N, N, 1, 0);
    run_instr(L_I, 3'b101, Y, N, 0, 0);
    run_instr(L_I, 3'b000, Y, N, 2, 0);
    run_instr(L_I, 3'b010, N, N, 0, 0);
    run_instr(L_JAL, 3'b000, N, N, 0, 0);
    run_instr(L_LUI, 3'b011, Y, N, 0, 0);
    run_instr(L_STORE, 3'b010, N, N, 3, 2);
    run_instr(L_R, 3'b000, N, N, MAXW, 0);
    run_instr(L_LOAD, 3'b010, N, N, 0, MAXW);
    run_instr(L_STORE, 3'b010, N, N, 0, MAXW);
    run_instr(L_LOAD, 3'b000, N, N, 0, 0);
    run_instr(L_BRANCH, 3'b100, N, N, 0, 0);
    for (int k = 0; k < 250; k++) begin
      case ($urandom_range(0, 9))
        0:       op = L_LOAD;
        1:       op = L_STORE;
        2:       op = L_R;
        3:       op = L_I;
        4:       op = L_BRANCH;
        5:       op = L_JAL;
        6:       op = L_LUI;
        default: op = 7'($urandom);
      endcase
      f3 = 3'($urandom);
      if ((op == L_LOAD || op == L_STORE) &&
          $urandom_range(0, 3) != 0) f3 = 3'b010;
      if (op == L_BRANCH &&
          $urandom_range(0, 3) != 0)
        f3 = {2'b00, 1'($urandom)};
      run_instr(op, f3, 1'($urandom),
                1'($urandom), rnd_wait(),
                rnd_wait());
    end
    $display("%0d/%0d checks passed",
             n_pass, n_chk);
    $finish;
  end

endmodule
